// File: rtl/timer_cfg_sequencer.sv
// timer_cfg_sequencer: shadows timer/prescaler configuration and applies it at a prescale-safe point,
// and runs the debug-halt request/acknowledge handshake with the prescaler stage.
module timer_cfg_sequencer #(
  parameter int MAX_WAIT = 512,
  parameter int WCNT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_wr,
  input  logic       cfg_timer_en,
  input  logic       cfg_div_en,
  input  logic [3:0] cfg_div_val,
  output logic       cfg_busy,
  output logic       cfg_err,
  output logic       upd_done,
  output logic       upd_forced,
  output logic       timer_en,
  output logic       div_en,
  output logic [3:0] div_val,
  input  logic       cnt_en,
  input  logic       dbg_mode,
  input  logic       dbg_halt_in,
  output logic       halt_req,
  input  logic       halt_ack,
  output logic       halted
);
  typedef enum logic {U_IDLE, U_WAIT} ustate_t;
  typedef enum logic [1:0] {H_RUN, H_REQ, H_HALT, H_REL} hstate_t;
  localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(MAX_WAIT - 1);
  ustate_t u_q, u_d;
  hstate_t h_q, h_d;
  logic [5:0] sh_q, sh_d, app_q, app_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic err_q, err_d, done_q, done_d, forced_q, forced_d;
  logic safe, tmo, hcond;
  always_comb begin
    hcond = dbg_mode & dbg_halt_in;
    // a divider change is harmless when the prescaler is idle, at a boundary, or frozen
    safe = !app_q[5] | !app_q[4] | cnt_en | (h_q == H_HALT);
    tmo = wcnt_q == WLAST;
    u_d = u_q;
    sh_d = sh_q;
    app_d = app_q;
    wcnt_d = wcnt_q;
    err_d = 1'b0;
    done_d = 1'b0;
    forced_d = 1'b0;
    if (u_q == U_IDLE) begin
      if (cfg_wr) begin
        u_d = U_WAIT;
        sh_d = {cfg_timer_en, cfg_div_en, cfg_div_val};
        wcnt_d = '0;
      end
    end else begin
      err_d = cfg_wr;
      if (safe || tmo) begin
        u_d = U_IDLE;
        app_d = sh_q;
        done_d = 1'b1;
        forced_d = !safe;
      end else begin
        wcnt_d = wcnt_q + WCNT_W'(1);
      end
    end
    case (h_q)
      H_RUN:   h_d = hcond ? H_REQ : H_RUN;
      H_REQ:   h_d = halt_ack ? H_HALT : (hcond ? H_REQ : H_RUN);
      H_HALT:  h_d = hcond ? H_HALT : H_REL;
      default: h_d = halt_ack ? H_REL : H_RUN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_q <= U_IDLE;
      h_q <= H_RUN;
      sh_q <= '0;
      app_q <= '0;
      wcnt_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      forced_q <= 1'b0;
    end else begin
      u_q <= u_d;
      h_q <= h_d;
      sh_q <= sh_d;
      app_q <= app_d;
      wcnt_q <= wcnt_d;
      err_q <= err_d;
      done_q <= done_d;
      forced_q <= forced_d;
    end
  end
  assign cfg_busy = u_q == U_WAIT;
  assign cfg_err = err_q;
  assign upd_done = done_q;
  assign upd_forced = forced_q;
  assign {timer_en, div_en, div_val} = app_q;
  assign halt_req = (h_q == H_REQ) || (h_q == H_HALT);
  assign halted = h_q == H_HALT;
endmodule
